// File: rtl/gmii_rx_chk.sv
// GMII receive frame checker: strips/validates preamble+SFD, counts bytes, checks FCS residue.
// Latency: verdict and frame_done appear one cycle after the edge that samples the first dv=0.
// Backpressure: none; the GMII stream cannot be stalled, so every byte is consumed on arrival.
//
// Ports:
//   clk, rst_n                    - 125 MHz GMII receive clock, async active-low reset
//   gmii_rxd/gmii_rx_dv/gmii_rx_er - GMII receive bus from the PCS
//   clr_cnt                       - synchronous clear of good_cnt/bad_cnt
//   frame_done                    - one-cycle pulse when a frame verdict is valid
//   frame_good, frame_len, err_*  - verdict fields, held until the next frame_done
//   good_cnt, bad_cnt             - saturating frame counters
module gmii_rx_chk #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic             clr_cnt,
    output logic             frame_done,
    output logic             frame_good,
    output logic [10:0]      frame_len,
    output logic             err_pre,
    output logic             err_crc,
    output logic             err_len,
    output logic             err_er,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    // Register value left after running the CRC over data plus a correct FCS.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;
    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    localparam logic [2:0]  PRE_MAX     = 3'd7;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] len_q, len_d;
    logic [2:0]  pre_q, pre_d;     // number of 0x55 bytes seen so far
    logic        er_q, er_d;       // rx_er seen during the current frame

    // Report bus produced by the FSM in the cycle that ends a frame.
    logic        rpt_vld;
    logic        rpt_good;
    logic [10:0] rpt_len;
    logic        rpt_pre;
    logic        rpt_crc;
    logic        rpt_len_err;
    logic        rpt_er;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= 11'd0;
            pre_q   <= 3'd0;
            er_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            pre_q   <= pre_d;
            er_q    <= er_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        pre_d       = pre_q;
        er_d        = er_q;
        rpt_vld     = 1'b0;
        rpt_good    = 1'b0;
        rpt_len     = 11'd0;
        rpt_pre     = 1'b0;
        rpt_crc     = 1'b0;
        rpt_len_err = 1'b0;
        rpt_er      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gmii_rx_dv) begin
                    // Fresh frame: error flag restarts with this byte's rx_er.
                    er_d  = gmii_rx_er;
                    crc_d = CRC_INIT;
                    len_d = 11'd0;
                    pre_d = 3'd1;
                    if (gmii_rxd == PRE_BYTE) begin
                        state_d = S_PRE;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_PRE: begin
                if (gmii_rx_dv) begin
                    er_d = er_q | gmii_rx_er;
                    if (gmii_rxd == PRE_BYTE) begin
                        // An eighth 0x55 means the preamble is too long.
                        if (pre_q == PRE_MAX) begin
                            state_d = S_DROP;
                        end else begin
                            pre_d = pre_q + 3'd1;
                        end
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_d = S_DATA;
                        crc_d   = CRC_INIT;
                        len_d   = 11'd0;
                    end else begin
                        state_d = S_DROP;
                    end
                end else begin
                    rpt_vld = 1'b1;
                    rpt_pre = 1'b1;
                    rpt_er  = er_q;
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (gmii_rx_dv) begin
                    er_d  = er_q | gmii_rx_er;
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    if (len_q != LEN_SAT) begin
                        len_d = len_q + 11'd1;
                    end
                end else begin
                    rpt_vld     = 1'b1;
                    rpt_len     = len_q;
                    rpt_crc     = (crc_q != CRC_RESIDUE);
                    rpt_len_err = (len_q < MIN_L) || (len_q > MAX_L);
                    rpt_er      = er_q;
                    rpt_good    = !(rpt_crc || rpt_len_err || er_q);
                    state_d     = S_IDLE;
                end
            end

            S_DROP: begin
                if (gmii_rx_dv) begin
                    er_d = er_q | gmii_rx_er;
                end else begin
                    rpt_vld = 1'b1;
                    rpt_pre = 1'b1;
                    rpt_er  = er_q;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Verdict registers: frame_done pulses, the rest hold until the next report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= 11'd0;
            err_pre    <= 1'b0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_er     <= 1'b0;
        end else begin
            frame_done <= rpt_vld;
            if (rpt_vld) begin
                frame_good <= rpt_good;
                frame_len  <= rpt_len;
                err_pre    <= rpt_pre;
                err_crc    <= rpt_crc;
                err_len    <= rpt_len_err;
                err_er     <= rpt_er;
            end
        end
    end

    // Counters advance while frame_done is high; a simultaneous clear drops that frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (clr_cnt) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (frame_done) begin
            if (frame_good) begin
                if (!(&good_cnt)) begin
                    good_cnt <= good_cnt + CNT_ONE;
                end
            end else begin
                if (!(&bad_cnt)) begin
                    bad_cnt <= bad_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_chk.sv
// Directed testbench for gmii_rx_chk: builds GMII byte streams with a reference FCS,
// drives them one byte per clock and checks verdicts, counters and reset behaviour.
// A second instance with 4-bit counters shares the inputs to exercise saturation.
module tb_gmii_rx_chk;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        clr_cnt;

    logic        frame_done, frame_good, err_pre, err_crc, err_len, err_er;
    logic [10:0] frame_len;
    logic [15:0] good_cnt, bad_cnt;

    logic        frame_done4, frame_good4, err_pre4, err_crc4, err_len4, err_er4;
    logic [10:0] frame_len4;
    logic [3:0]  good_cnt4, bad_cnt4;

    logic [3:0]  flags;
    assign flags = {err_pre, err_crc, err_len, err_er};

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int p0;

    logic [7:0] fb[$];

    gmii_rx_chk #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .clr_cnt    (clr_cnt),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .frame_len  (frame_len),
        .err_pre    (err_pre),
        .err_crc    (err_crc),
        .err_len    (err_len),
        .err_er     (err_er),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    gmii_rx_chk #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .clr_cnt    (clr_cnt),
        .frame_done (frame_done4),
        .frame_good (frame_good4),
        .frame_len  (frame_len4),
        .err_pre    (err_pre4),
        .err_crc    (err_crc4),
        .err_len    (err_len4),
        .err_er     (err_er4),
        .good_cnt   (good_cnt4),
        .bad_cnt    (bad_cnt4)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC-32 (reflected, poly 0xEDB88320).
    function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        b;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            b = c[0] ^ d[i];
            c = c >> 1;
            if (b) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // npre x 0x55, SFD, plen payload bytes, then the 4-byte FCS (LSB first).
    task automatic build_good(input int npre, input int plen);
        logic [31:0] crc;
        logic [7:0]  b;
        logic [31:0] fcs;
        fb.delete();
        for (int i = 0; i < npre; i++) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'((i * 37 + 11) & 255);
            fb.push_back(b);
            crc = ref_crc(crc, b);
        end
        fcs = ~crc;
        fb.push_back(fcs[7:0]);
        fb.push_back(fcs[15:8]);
        fb.push_back(fcs[23:16]);
        fb.push_back(fcs[31:24]);
    endtask

    // Drive fb one byte per cycle, rx_er on index er_idx (-1 = none), then dv low.
    task automatic drive_stream(input int er_idx);
        for (int i = 0; i < fb.size(); i++) begin
            @(negedge clk);
            gmii_rxd   = fb[i];
            gmii_rx_dv = 1'b1;
            gmii_rx_er = (i == er_idx);
        end
        @(negedge clk);
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
    endtask

    // Verdict is due exactly one cycle after dv low is driven, and lasts one cycle.
    task automatic expect_frame(input string tag, input logic good, input int len,
                                input logic [3:0] exp_flags);
        @(negedge clk);
        check({tag, "_done"}, frame_done, 1);
        check({tag, "_good"}, frame_good, good);
        check({tag, "_len"}, frame_len, len);
        check({tag, "_flags"}, flags, exp_flags);
        @(negedge clk);
        check({tag, "_pulse"}, frame_done, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        clr_cnt    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", frame_done, 0);
        check("rst_good", frame_good, 0);
        check("rst_len", frame_len, 0);
        check("rst_flags", flags, 0);
        check("rst_gcnt", good_cnt, 0);
        check("rst_bcnt", bad_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good 64-byte frame with full preamble
        build_good(7, 60);
        drive_stream(-1);
        expect_frame("good64", 1'b1, 64, 4'b0000);
        check("good64_gcnt", good_cnt, 1);
        check("good64_bcnt", bad_cnt, 0);
        repeat (3) @(negedge clk);
        check("good64_hold", frame_good, 1);

        // Single payload bit flipped
        build_good(7, 60);
        fb[8 + 5] = fb[8 + 5] ^ 8'h04;
        drive_stream(-1);
        expect_frame("bitflip", 1'b0, 64, 4'b0100);
        check("bitflip_bcnt", bad_cnt, 1);

        // rx_er for one cycle at frame byte 40
        build_good(7, 60);
        drive_stream(8 + 40);
        expect_frame("rxer", 1'b0, 64, 4'b0001);
        check("rxer_bcnt", bad_cnt, 2);

        // SFD only, no preamble
        build_good(0, 60);
        drive_stream(-1);
        expect_frame("sfdonly", 1'b1, 64, 4'b0000);
        check("sfdonly_gcnt", good_cnt, 2);

        // Eight 0x55 bytes: preamble too long
        build_good(8, 60);
        drive_stream(-1);
        expect_frame("pre8", 1'b0, 0, 4'b1000);

        // 0x55 0x55 0xAA then junk
        fb.delete();
        fb.push_back(8'h55);
        fb.push_back(8'h55);
        fb.push_back(8'hAA);
        for (int i = 0; i < 10; i++) fb.push_back(8'(i + 1));
        drive_stream(-1);
        expect_frame("badsfd", 1'b0, 0, 4'b1000);
        check("badsfd_bcnt", bad_cnt, 4);

        // Runt: 60 bytes with valid FCS
        build_good(7, 56);
        drive_stream(-1);
        expect_frame("runt", 1'b0, 60, 4'b0010);

        // Oversize: 1519 bytes with valid FCS
        build_good(7, 1515);
        drive_stream(-1);
        expect_frame("giant", 1'b0, 1519, 4'b0010);
        check("giant_bcnt", bad_cnt, 6);

        // Clear, then two good frames separated by one idle cycle
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_gcnt", good_cnt, 0);
        check("clr_bcnt", bad_cnt, 0);
        p0 = pulses;
        build_good(7, 60);
        drive_stream(-1);
        build_good(7, 60);
        drive_stream(-1);
        expect_frame("b2b", 1'b1, 64, 4'b0000);
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_gcnt", good_cnt, 2);

        // Saturation: 4-bit counter instance after 20 good frames
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int f = 0; f < 20; f++) begin
            build_good(7, 60);
            drive_stream(-1);
            repeat (2) @(negedge clk);
        end
        check("sat_gcnt4", good_cnt4, 15);
        check("sat_gcnt16", good_cnt, 20);
        check("sat_bcnt4", bad_cnt4, 0);

        // clr_cnt coincident with frame_done: clear wins
        build_good(7, 60);
        drive_stream(-1);
        @(negedge clk);
        check("clrhit_done", frame_done, 1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clrhit_gcnt", good_cnt, 0);
        check("clrhit_bcnt", bad_cnt, 0);

        // Reset mid-frame
        build_good(7, 60);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            gmii_rxd   = fb[i];
            gmii_rx_dv = 1'b1;
        end
        p0 = pulses;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_good", frame_good, 0);
        check("midrst_len", frame_len, 0);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_flags", flags, 0);

        // Normal operation after reset
        build_good(7, 60);
        drive_stream(-1);
        expect_frame("postrst", 1'b1, 64, 4'b0000);
        check("postrst_gcnt", good_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gmii_rx_chk.md
Name: gmii_rx_chk

Overview:
- Receive-side frame checker. Consumes the GMII receive bus from the 1000BASE-X PCS/PMA core: the loopback or link-partner return path of the GMII transmit frame generator.
- Strips and validates the preamble/SFD, counts frame bytes, and checks the Ethernet FCS (CRC-32).
- Reports a per-frame verdict and keeps saturating good/bad frame counters for ILA/register readout.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS inclusive)
CNT_W, 16, width of good/bad frame counters

Ports:
clk  input  1  GMII receive clock (125 MHz); single clock domain
rst_n  input  1  reset, asynchronous, active-low
gmii_rxd  input  8  receive data from PCS
gmii_rx_dv  input  1  receive data valid
gmii_rx_er  input  1  receive error
clr_cnt  input  1  synchronous clear of good_cnt/bad_cnt
frame_done  output  1  one-cycle pulse: frame verdict valid
frame_good  output  1  verdict: 1 = no errors (valid with frame_done, held until next frame_done)
frame_len  output  11  bytes after SFD including FCS, saturates at 2047 (held like frame_good)
err_pre  output  1  bad preamble/SFD (held)
err_crc  output  1  FCS residue mismatch (held)
err_len  output  1  length outside MIN_LEN..MAX_LEN (held)
err_er  output  1  gmii_rx_er seen while gmii_rx_dv=1 (held)
good_cnt  output  CNT_W  count of good frames, saturating
bad_cnt  output  CNT_W  count of bad frames, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 0xFFFFFFFF; byte counter 0.
- Inputs are sampled directly on the clk rising edge; all outputs are registered.
- States:
  - IDLE:
    - dv=1 and rxd=0x55 -> PREAMBLE.
    - dv=1 and rxd=0xD5 -> DATA (a shrunk preamble is legal).
    - dv=1 with any other byte -> DROP, err_pre pending.
  - PREAMBLE:
    - dv=1 and rxd=0x55 -> stay; more than 7 consecutive 0x55 -> DROP, err_pre pending.
    - dv=1 and rxd=0xD5 -> DATA; CRC reinitialised to 0xFFFFFFFF; byte counter cleared.
    - dv=1 with other byte -> DROP, err_pre pending.
    - dv=0 -> report bad frame, err_pre=1, frame_len=0; -> IDLE.
  - DATA:
    - each dv=1 byte: counter +1 (saturate 2047); CRC updated with reflected CRC-32 (poly 0xEDB88320, LSB first).
    - dv=0 -> evaluate, pulse frame_done; -> IDLE.
  - DROP: ignore data until dv=0, then report bad frame with err_pre=1; -> IDLE.
- Evaluation at end of DATA:
  - err_crc = (crc_reg != 0xDEBB20E3), where crc_reg has run over DA..FCS.
  - err_len = (len < MIN_LEN or len > MAX_LEN).
  - frame_good = no err_* flag set.
- err_er: latched if rx_er=1 while dv=1 in any non-IDLE state, including the cycle dv rises. rx_er while dv=0 (carrier extension/false carrier) is ignored.
- Timing: frame_done is high exactly one cycle, in the cycle after the edge that samples the first dv=0. All verdict outputs update on that same edge.
- Back-to-back frames: one dv=0 cycle between frames is sufficient. A dv=1 on the cycle right after frame_done is processed from IDLE.
- Counters:
  - Increment on frame_done: good_cnt if frame_good, else bad_cnt.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt=1 zeroes both; if coincident with frame_done, clear wins and that frame is not counted.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The partial frame is never reported.

Test Plan:
- 7x0x55, 0xD5, 60 payload bytes + correct FCS (bench CRC model), dv low -> one frame_done pulse, frame_good=1, frame_len=64, good_cnt=1, bad_cnt=0.
- Same frame with 1 payload bit flipped -> frame_good=0, err_crc=1, others 0, bad_cnt=1.
- Same good frame with rx_er=1 for one cycle at byte 40 -> err_er=1, err_crc=0, frame_good=0.
- Preamble variants:
  - SFD only (no 0x55): good, frame_len=64.
  - 8x0x55: err_pre=1.
  - 0x55,0x55,0xAA: err_pre=1, frame_len=0.
- Good 60-byte frame (valid FCS) -> err_len=1. 1519-byte frame -> err_len=1, frame_len=1519. Two good frames separated by a single dv=0 cycle -> two frame_done pulses, good_cnt=2.
- Counter behaviour:
  - Preload near saturation (CNT_W=4 build): 20 good frames -> good_cnt=15.
  - clr_cnt coincident with frame_done -> good_cnt=0.
  - rst_n low mid-frame -> no frame_done, all outputs 0.
